kth_apb_job_sequencer: RTL and testbench

Synthesizable APB master that runs one complete fabric job on the `kth_ss` APB slave: per-cell instruction load, input-buffer load, call, ret polling and output-buffer readback. It replaces host-driven register poking with a parametrised, multi-cell engine with proper two-phase APB, PREADY wait states, PSLVERR abort and stream interfaces for payload in and out. It sits between a host/DMA stream source and the `kth_ss` APB port.

---
 rtl/kth_apb_job_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_kth_apb_job_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kth_apb_job_sequencer.sv
// kth_apb_job_sequencer: APB3 master that runs one complete fabric job on kth_ss.
// Flow: per-cell select + instruction load, input load, call, ret polling, readback.
//
// Ports:
//   clk_in, reset_int (async, active-low)
//   start, cell_mask        : job request, sampled in IDLE
//   busy, done, error,
//   err_code                : job status (00 none, 01 PSLVERR, 10 timeout, 11 empty mask)
//   in_valid/in_ready/in_data    : payload stream (instructions, then input data)
//   out_valid/out_ready/out_data : readback stream
//   PADDR..PSLVERR          : APB3 master
//
// Build option: define KTH_SEQ_TIMEOUT_EN to bound ret polling to POLL_TIMEOUT polls.
module kth_apb_job_sequencer #(
    parameter int unsigned NUM_CELLS          = 1,
    parameter int unsigned INSTR_WORDS        = 64,
    parameter int unsigned DATA_IN_WORDS      = 24,
    parameter int unsigned DATA_OUT_WORDS     = 16,
    parameter logic [31:0] INSTR_BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] DATA_IN_BASE_ADDR  = 32'h0000_1000,
    parameter logic [31:0] DATA_OUT_BASE_ADDR = 32'h0000_2000,
    parameter logic [31:0] CTRL_BASE_ADDR     = 32'h0000_3000,
    parameter int unsigned POLL_GAP           = 4,
    parameter int unsigned POLL_TIMEOUT       = 65535
) (
    input  logic                 clk_in,
    input  logic                 reset_int,
    input  logic                 start,
    input  logic [NUM_CELLS-1:0] cell_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [31:0]          PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    typedef enum logic [3:0] {
        IDLE,
        SEL,
        FETCH,
        SETUP,
        ACCESS,
        CALL,
        POLL_WAIT,
        POLL,
        READ,
        PUSH,
        FINISH
    } state_t;

    // What the transfer in flight belongs to; decides where ACCESS goes next.
    typedef enum logic [2:0] {
        PH_CELL,
        PH_INSTR,
        PH_DIN,
        PH_CALL,
        PH_POLL,
        PH_READ
    } phase_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SLV     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_MASK    = 2'b11;

    localparam logic [15:0] INSTR_LAST = 16'(INSTR_WORDS - 1);
    localparam logic [15:0] DIN_LAST   = 16'(DATA_IN_WORDS - 1);
    localparam logic [15:0] DOUT_LAST  = 16'(DATA_OUT_WORDS - 1);

    state_t               state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [NUM_CELLS-1:0] mask_q, mask_d;
    logic [15:0]          idx_q, idx_d;
    logic [15:0]          gap_q, gap_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 error_q, error_d;
    logic [1:0]           code_q, code_d;
`ifdef KTH_SEQ_TIMEOUT_EN
    logic [31:0]          poll_q, poll_d;
`endif

    logic [3:0]  sel_cell;
    logic [31:0] word_off;

    assign word_off = {14'h0, idx_q, 2'b00};

    // Lowest remaining cell; cells are served in ascending order.
    always_comb begin
        sel_cell = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_cell = 4'(i);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            state_q <= IDLE;
            phase_q <= PH_CELL;
            mask_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
`ifdef KTH_SEQ_TIMEOUT_EN
            poll_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            code_q  <= code_d;
`ifdef KTH_SEQ_TIMEOUT_EN
            poll_q  <= poll_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        error_d = error_q;
        code_d  = code_q;
`ifdef KTH_SEQ_TIMEOUT_EN
        poll_d  = poll_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    code_d  = ERR_NONE;
                    if (cell_mask == '0) begin
                        error_d = 1'b1;
                        code_d  = ERR_MASK;
                        state_d = FINISH;
                    end else begin
                        mask_d  = cell_mask;
                        state_d = SEL;
                    end
                end
            end
            SEL: begin
                if (mask_q == '0) begin
                    phase_d = PH_DIN;
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    phase_d = PH_CELL;
                    addr_d  = CTRL_BASE_ADDR;
                    wdata_d = {28'h0, sel_cell};
                    write_d = 1'b1;
                    // drop the lowest set bit: that cell is now being served
                    mask_d  = mask_q & (mask_q - NUM_CELLS'(1));
                    state_d = SETUP;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    wdata_d = in_data;
                    write_d = 1'b1;
                    addr_d  = ((phase_q == PH_INSTR) ? INSTR_BASE_ADDR
                                                     : DATA_IN_BASE_ADDR) + word_off;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        error_d = 1'b1;
                        code_d  = ERR_SLV;
                        state_d = FINISH;
                    end else begin
                        unique case (phase_q)
                            PH_CELL: begin
                                idx_d   = '0;
                                phase_d = PH_INSTR;
                                state_d = FETCH;
                            end
                            PH_INSTR: begin
                                if (idx_q == INSTR_LAST) begin
                                    state_d = SEL;
                                end else begin
                                    idx_d   = idx_q + 16'd1;
                                    state_d = FETCH;
                                end
                            end
                            PH_DIN: begin
                                if (idx_q == DIN_LAST) begin
                                    state_d = CALL;
                                end else begin
                                    idx_d   = idx_q + 16'd1;
                                    state_d = FETCH;
                                end
                            end
                            PH_CALL: begin
                                state_d = POLL;
                            end
                            PH_POLL: begin
                                if (PRDATA[0]) begin
                                    idx_d   = '0;
                                    state_d = READ;
                                end else begin
                                    gap_d   = '0;
                                    state_d = POLL_WAIT;
                                end
                            end
                            PH_READ: begin
                                rdata_d = PRDATA;
                                state_d = PUSH;
                            end
                            default: begin
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
            end
            CALL: begin
                addr_d  = CTRL_BASE_ADDR + 32'd4;
                wdata_d = 32'h1;
                write_d = 1'b1;
                phase_d = PH_CALL;
`ifdef KTH_SEQ_TIMEOUT_EN
                poll_d  = '0;
`endif
                state_d = SETUP;
            end
            POLL_WAIT: begin
                if (32'(gap_q) + 32'd1 >= POLL_GAP) begin
                    state_d = POLL;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            POLL: begin
`ifdef KTH_SEQ_TIMEOUT_EN
                if (poll_q >= POLL_TIMEOUT) begin
                    error_d = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = FINISH;
                end else begin
                    poll_d  = poll_q + 32'd1;
                    addr_d  = CTRL_BASE_ADDR + 32'd8;
                    write_d = 1'b0;
                    phase_d = PH_POLL;
                    state_d = SETUP;
                end
`else
                addr_d  = CTRL_BASE_ADDR + 32'd8;
                write_d = 1'b0;
                phase_d = PH_POLL;
                state_d = SETUP;
`endif
            end
            READ: begin
                addr_d  = DATA_OUT_BASE_ADDR + word_off;
                write_d = 1'b0;
                phase_d = PH_READ;
                state_d = SETUP;
            end
            PUSH: begin
                if (out_ready) begin
                    if (idx_q == DOUT_LAST) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = READ;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status and strobes decode straight from the state register so an
    // asynchronous reset clears them immediately.
    assign busy      = (state_q != IDLE) && (state_q != FINISH);
    assign done      = (state_q == FINISH);
    assign error     = error_q;
    assign err_code  = code_q;
    assign in_ready  = (state_q == FETCH);
    assign out_valid = (state_q == PUSH);
    assign out_data  = rdata_q;
    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = wdata_q;

endmodule

// File: tb/tb_kth_apb_job_sequencer.sv
// tb_kth_apb_job_sequencer: randomized job runs against a transaction-list model.
// Slave, payload source and readback sink are driven from one per-cycle task.
module tb_kth_apb_job_sequencer;

    localparam int NC  = 4;
    localparam int IW  = 8;
    localparam int DIW = 5;
    localparam int DOW = 4;
    localparam int GAP = 2;
    localparam int PTO = 8;
    localparam logic [31:0] IB = 32'h0000_0000;
    localparam logic [31:0] DB = 32'h0000_1000;
    localparam logic [31:0] OB = 32'h0000_2000;
    localparam logic [31:0] CB = 32'h0000_3000;

    logic          clk_in = 1'b0;
    logic          reset_int = 1'b0;
    logic          start = 1'b0;
    logic [NC-1:0] cell_mask = '0;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [31:0]   PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    kth_apb_job_sequencer #(
        .NUM_CELLS(NC), .INSTR_WORDS(IW), .DATA_IN_WORDS(DIW),
        .DATA_OUT_WORDS(DOW), .INSTR_BASE_ADDR(IB), .DATA_IN_BASE_ADDR(DB),
        .DATA_OUT_BASE_ADDR(OB), .CTRL_BASE_ADDR(CB), .POLL_GAP(GAP),
        .POLL_TIMEOUT(PTO)
    ) dut (
        .clk_in(clk_in), .reset_int(reset_int), .start(start),
        .cell_mask(cell_mask), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk_in = ~clk_in;

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int          waits, ret_after, err_at, rnd_mode;
    logic [31:0] salt;
    int          pay_ptr, xfer_n, poll_n, done_cnt, psel_cyc, unstable, wait_left;
    bit          in_hs;
    logic [31:0] s_addr, s_dat;
    logic        s_wr;

    logic [31:0] payload[$];
    logic [31:0] obs_addr[$], obs_dat[$], obs_out[$];
    bit          obs_wr[$];
    logic [31:0] exp_addr[$], exp_dat[$], exp_out[$];
    bit          exp_wr[$], exp_isp[$];

    function automatic logic [31:0] dout_word(input logic [31:0] addr);
        return 32'hC0DE_0000 ^ (addr << 4) ^ salt;
    endfunction

    // One clock: everything is evaluated at the falling edge and the
    // handshakes it sets up complete at the following rising edge.
    task automatic tick();
        @(negedge clk_in);
        if (in_hs) pay_ptr++;
        in_valid = (pay_ptr < payload.size()) &&
                   (rnd_mode == 0 || $urandom_range(0, 1) == 1);
        in_data  = (pay_ptr < payload.size()) ? payload[pay_ptr] : 32'h0;
        in_hs    = in_valid && in_ready;
        out_ready = (rnd_mode == 0) || ($urandom_range(0, 1) == 1);
        if (out_valid && out_ready) obs_out.push_back(out_data);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
        if (PSEL && !PENABLE) begin
            psel_cyc++;
            wait_left = waits;
            s_addr = PADDR;
            s_wr   = PWRITE;
            s_dat  = PWDATA;
        end else if (PSEL && PENABLE) begin
            psel_cyc++;
            if (PADDR != s_addr || PWRITE != s_wr || (PWRITE && PWDATA != s_dat))
                unstable++;
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                PREADY = 1'b1;
                xfer_n++;
                obs_addr.push_back(PADDR);
                obs_wr.push_back(PWRITE);
                obs_dat.push_back(PWRITE ? PWDATA : 32'h0);
                if (xfer_n == err_at) PSLVERR = 1'b1;
                if (!PWRITE) begin
                    if (PADDR == CB + 32'd8) begin
                        poll_n++;
                        PRDATA = (poll_n >= ret_after) ? 32'hFFFF_FFF1 : 32'hFFFF_FFFE;
                    end else begin
                        PRDATA = dout_word(PADDR);
                    end
                end
            end
        end
        if (done) done_cnt++;
    endtask

    task automatic prep_job(input logic [NC-1:0] mask, input int w, input int r,
                            input int e, input int rm);
        waits = w; ret_after = r; err_at = e; rnd_mode = rm;
        salt = $urandom;
        pay_ptr = 0; xfer_n = 0; poll_n = 0; done_cnt = 0;
        psel_cyc = 0; unstable = 0; wait_left = 0; in_hs = 1'b0;
        payload.delete(); obs_addr.delete(); obs_dat.delete();
        obs_wr.delete(); obs_out.delete();
        exp_addr.delete(); exp_dat.delete(); exp_wr.delete();
        exp_isp.delete(); exp_out.delete();
        for (int k = 0; k < $countones(mask) * IW + DIW; k++)
            payload.push_back($urandom);
    endtask

    function automatic void add(input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input bit isp);
        exp_wr.push_back(wr);
        exp_addr.push_back(a);
        exp_dat.push_back(d);
        exp_isp.push_back(isp);
    endfunction

    task automatic kick(input logic [NC-1:0] mask);
        tick();
        start = 1'b1;
        cell_mask = mask;
        tick();
        start = 1'b0;
    endtask

    task automatic run_job(input logic [NC-1:0] mask, input int w, input int r,
                           input int e, input int rm, input int code);
        int k;
        int exp_pay;
        int n;
        prep_job(mask, w, r, e, rm);
        k = 0;
        if (mask != '0) begin
            for (int c = 0; c < NC; c++) begin
                if (mask[c]) begin
                    add(1, CB, 32'(c), 0);
                    for (int i = 0; i < IW; i++) add(1, IB + 32'(4 * i), payload[k++], 1);
                end
            end
            for (int i = 0; i < DIW; i++) add(1, DB + 32'(4 * i), payload[k++], 1);
            add(1, CB + 32'd4, 32'h1, 0);
            for (int i = 0; i < ((code == 2) ? PTO : r); i++) add(0, CB + 32'd8, 32'h0, 0);
            if (code == 0) begin
                for (int i = 0; i < DOW; i++) begin
                    add(0, OB + 32'(4 * i), 32'h0, 0);
                    exp_out.push_back(dout_word(OB + 32'(4 * i)));
                end
            end
        end
        if (e > 0) begin
            while (exp_addr.size() > e) begin
                void'(exp_addr.pop_back()); void'(exp_dat.pop_back());
                void'(exp_wr.pop_back()); void'(exp_isp.pop_back());
            end
            exp_out.delete();
        end
        exp_pay = 0;
        foreach (exp_isp[i]) exp_pay += int'(exp_isp[i]);

        kick(mask);
        check("busy_after_start", 32'(busy), 32'(mask != '0));
        for (int t = 0; t < 20000 && done_cnt == 0; t++) tick();
        check("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (6) tick();
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("error", 32'(error), 32'(code != 0));
        check("err_code", 32'(err_code), 32'(code));
        check("xfer_count", 32'(xfer_n), 32'(exp_addr.size()));
        check("payload_used", 32'(pay_ptr), 32'(exp_pay));
        check("out_count", 32'(obs_out.size()), 32'(exp_out.size()));
        check("apb_unstable", 32'(unstable), 32'd0);
        if (mask == '0) check("no_psel", 32'(psel_cyc), 32'd0);
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("x%0d_addr", i), obs_addr[i], exp_addr[i]);
            check($sformatf("x%0d_wr", i), 32'(obs_wr[i]), 32'(exp_wr[i]));
            check($sformatf("x%0d_data", i), obs_dat[i], exp_dat[i]);
        end
        n = (obs_out.size() < exp_out.size()) ? obs_out.size() : exp_out.size();
        for (int i = 0; i < n; i++)
            check($sformatf("out%0d", i), obs_out[i], exp_out[i]);
    endtask

    task automatic reset_mid_job();
        bit found;
        prep_job(4'b0110, 2, 2, 0, 0);
        kick(4'b0110);
        found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            tick();
            found = PSEL && PENABLE && (xfer_n >= 3);
        end
        check("reset_reach_access", 32'(found), 32'd1);
        reset_int = 1'b0;
        #1;
        check("rst_mid_psel", 32'(PSEL), 32'd0);
        check("rst_mid_penable", 32'(PENABLE), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_paddr", PADDR, 32'h0);
        tick();
        tick();
        reset_int = 1'b1;
    endtask

    initial begin
        waits = 0; ret_after = 1; err_at = 0; rnd_mode = 0; salt = '0;
        pay_ptr = 0; xfer_n = 0; poll_n = 0; done_cnt = 0;
        psel_cyc = 0; unstable = 0; wait_left = 0; in_hs = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        reset_int = 1'b1;

        run_job(4'b0001, 0, 5, 0, 0, 0);
        run_job(4'b1010, 0, 1, 0, 0, 0);
        run_job(4'b1111, 3, 3, 0, 1, 0);
        run_job(4'b0001, 0, 2, 11, 0, 1);
        run_job(4'b0000, 0, 1, 0, 0, 3);
`ifdef KTH_SEQ_TIMEOUT_EN
        run_job(4'b0001, 0, 1000, 0, 0, 2);
`endif
        for (int j = 0; j < 4; j++)
            run_job(NC'($urandom_range(1, 15)), $urandom_range(0, 2),
                    $urandom_range(1, 4), 0, 1, 0);
        reset_mid_job();
        run_job(4'b0101, 1, 2, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
